// File: rtl/syncram_stream_rdr.sv
// Burst read engine for a registered-read dual-port RAM. It streams bytes out through a 2-entry valid/ready FIFO.
// Optional read-parity checking is built only when SYNCRAM_RDR_PARITY_EN is defined.
module syncram_stream_rdr #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          start,
  input  logic [AW-1:0] sadr,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          ram_ce,
  output logic [AW-1:0] ram_adr,
  input  logic [DW-1:0] ram_o,
  input  logic          ram_op,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  input  logic          o_ready,
  output logic          perr
);

  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_ISSUE = 2'd1;
  localparam logic [1:0]    ST_DRAIN = 2'd2;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [AW-1:0] last_adr_q, last_adr_d;
  logic [AW:0]   icnt_q, icnt_d;
  logic [AW:0]   dcnt_q, dcnt_d;
  logic          done_q, done_d;
  logic          busy_q;
  logic          inflight_q;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    occ_q, occ_d;
  logic [2:0]    pending_s;
  logic          accept_s, credit_s, issue_s, pop_s, capture_s;

  assign accept_s  = (state_q == ST_IDLE) && start;
  assign pop_s     = o_valid && o_ready;
  assign capture_s = inflight_q;
  // A read may issue only if everything already owed to the FIFO still fits after this cycle's pop.
  assign pending_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign credit_s  = (pending_s < 3'd2);
  assign issue_s   = (state_q == ST_ISSUE) && credit_s;

  assign busy    = busy_q;
  assign done    = done_q;
  assign ram_ce  = issue_s;
  assign ram_adr = issue_s ? adr_q : last_adr_q;
  assign o_valid = (occ_q != 2'd0);
  assign o_data  = fifo_q[rd_ptr_q];
  assign o_last  = o_valid && (dcnt_q == CNT_ONE);

  // Burst control: state, address and the issue/delivery counters.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    last_adr_d = last_adr_q;
    icnt_d     = icnt_q;
    dcnt_d     = dcnt_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && (len != {(AW+1){1'b0}})) begin
          state_d = ST_ISSUE;
          adr_d   = sadr;
          icnt_d  = len;
          dcnt_d  = len;
        end else if (accept_s) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s) begin
          adr_d      = adr_q + ADR_ONE;
          last_adr_d = adr_q;
          icnt_d     = icnt_q - CNT_ONE;
          state_d    = (icnt_q == CNT_ONE) ? ST_DRAIN : ST_ISSUE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_DRAIN: state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
    if (pop_s) begin
      dcnt_d = dcnt_q - CNT_ONE;
      if (dcnt_q == CNT_ONE) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else begin
        done_d = done_d;
      end
    end else begin
      dcnt_d = dcnt_d;
    end
  end

  // FIFO occupancy: one capture in, one handshake out per cycle.
  always_comb begin
    occ_d = occ_q;
    case ({capture_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Control registers.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q    <= ST_IDLE;
      adr_q      <= '0;
      last_adr_q <= '0;
      icnt_q     <= '0;
      dcnt_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      last_adr_q <= last_adr_d;
      icnt_q     <= icnt_d;
      dcnt_q     <= dcnt_d;
      done_q     <= done_d;
      busy_q     <= (state_d != ST_IDLE);
      inflight_q <= issue_s;
    end
  end

  // Two-entry skid FIFO; data from the RAM lands here the cycle after the read is issued.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (capture_s) begin
        fifo_q[wr_ptr_q] <= ram_o;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_d;
    end
  end

`ifdef SYNCRAM_RDR_PARITY_EN
  function automatic logic parity_mismatch(input logic [DW-1:0] d, input logic p);
    return ((^d) != p);
  endfunction

  logic perr_q;

  // Sticky parity error, cleared by reset or by the next accepted burst request.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      perr_q <= 1'b0;
    end else if (accept_s) begin
      perr_q <= 1'b0;
    end else if (capture_s && parity_mismatch(ram_o, ram_op)) begin
      perr_q <= 1'b1;
    end
  end

  assign perr = perr_q;
`else
  logic unused_ram_op;
  assign unused_ram_op = ram_op;
  assign perr          = 1'b0;
`endif

endmodule

// File: tb/tb_syncram_stream_rdr.sv
// Self-checking bench for syncram_stream_rdr: a RAM model plus a byte/address scoreboard filled at burst launch.
module tb_syncram_stream_rdr;
  localparam int AW = 11;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst, start, ram_op, o_ready;
  logic [AW-1:0] sadr, ram_adr;
  logic [AW:0]   len;
  logic          busy, done, ram_ce, o_valid, o_last, perr;
  logic [DW-1:0] ram_o, o_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem  [2048];
  logic          flip [2048];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] adr_exp [$];

  int first_ce, first_v, last_hs, done_cyc;
  logic perr_c1;

  syncram_stream_rdr #(.AW(AW), .DW(DW)) dut (
    .rclk(rclk), .rrst(rrst), .start(start), .sadr(sadr), .len(len),
    .busy(busy), .done(done), .ram_ce(ram_ce), .ram_adr(ram_adr),
    .ram_o(ram_o), .ram_op(ram_op), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .o_ready(o_ready), .perr(perr)
  );

  always #5 rclk = ~rclk;

  // Registered-read RAM model with per-address parity corruption.
  always @(posedge rclk) begin
    if (ram_ce) begin
      ram_o  <= mem[ram_adr];
      ram_op <= (^mem[ram_adr]) ^ flip[ram_adr];
    end
  end

  task automatic launch(input logic [AW-1:0] a, input logic [AW:0] l);
    logic [AW-1:0] idx;
    @(negedge rclk);
    start = 1'b1; sadr = a; len = l; o_ready = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      idx = a + AW'(i);
      exp_q.push_back({(i == int'(l) - 1), mem[idx]});
      adr_exp.push_back(idx);
    end
  endtask

  // mode 0: ready always, 1: ready 1,0,0 repeating, 2: random ready. poke: assert start mid-burst.
  task automatic run_burst(input int mode, input int budget, input bit poke, input string tag);
    int issued = 0;
    int popped = 0;
    bit stall = 1'b0;
    logic [DW:0] held = '0;
    logic [DW:0] e;
    logic [AW-1:0] ea;
    first_ce = -1; first_v = -1; last_hs = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge rclk);
      start = poke && (cyc >= 2) && (cyc <= 4);
      sadr = 11'h7AA; len = 12'd3;
      case (mode)
        1:       o_ready = ((cyc - 1) % 3 == 0);
        2:       o_ready = 1'($urandom_range(1, 0));
        default: o_ready = 1'b1;
      endcase
      #1;
      if (cyc == 1) perr_c1 = perr;
      if (stall) begin
        n_cmp++;
        if (!o_valid || {o_last, o_data} !== held) begin
          n_err++;
          $display("FAIL %s hold cyc %0d: got v=%b %h required v=1 %h", tag, cyc, o_valid, {o_last, o_data}, held);
        end
      end
      if (ram_ce) begin
        issued++;
        if (first_ce < 0) first_ce = cyc;
        n_cmp++;
        if (adr_exp.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_read cyc %0d: got adr %h required none", tag, cyc, ram_adr);
        end else begin
          ea = adr_exp.pop_front();
          if (ram_adr !== ea) begin
            n_err++;
            $display("FAIL %s ram_adr cyc %0d: got %h required %h", tag, cyc, ram_adr, ea);
          end
        end
      end
      if (o_valid && first_v < 0) first_v = cyc;
      if (o_valid && o_ready) begin
        popped++;
        last_hs = cyc;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL %s extra_byte cyc %0d: got %h required none", tag, cyc, o_data);
        end else begin
          e = exp_q.pop_front();
          if ({o_last, o_data} !== e) begin
            n_err++;
            $display("FAIL %s byte cyc %0d: got last=%b %h required last=%b %h", tag, cyc, o_last, o_data, e[DW], e[DW-1:0]);
          end
        end
      end
      if (ram_ce) begin
        n_cmp++;
        if (issued - popped > 2) begin
          n_err++;
          $display("FAIL %s outstanding cyc %0d: got %0d required <=2", tag, cyc, issued - popped);
        end
      end
      stall = o_valid && !o_ready;
      held  = {o_last, o_data};
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    n_cmp++;
    if (done_cyc < 0 || exp_q.size() != 0 || adr_exp.size() != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s completion: got done_cyc=%0d left=%0d/%0d busy=%b required done, 0/0, busy=0",
               tag, done_cyc, exp_q.size(), adr_exp.size(), busy);
    end
    exp_q.delete();
    adr_exp.delete();
  endtask

  task automatic test_reset();
    rrst = 1'b1; start = 1'b0; sadr = '0; len = '0; o_ready = 1'b0;
    repeat (3) @(negedge rclk);
    #1;
    n_cmp++;
    if ({busy, done, ram_ce, ram_adr, o_valid, o_data, o_last, perr} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_values: got %h required 0", {busy, done, ram_ce, ram_adr, o_valid, o_data, o_last, perr});
    end
    rrst = 1'b0;
  endtask

  task automatic test_basic();
    launch(11'h010, 12'd4);
    run_burst(0, 20, 1'b0, "basic");
    n_cmp++;
    if (first_ce != 1 || first_v != 3 || last_hs != 6 || done_cyc != 7) begin
      n_err++;
      $display("FAIL basic_timing: got ce=%0d v=%0d hs=%0d done=%0d required 1 3 6 7", first_ce, first_v, last_hs, done_cyc);
    end
  endtask

  task automatic test_wrap();
    launch(11'h7FE, 12'd4);
    run_burst(0, 20, 1'b0, "wrap");
    n_cmp++;
    if (done_cyc != 7) begin
      n_err++;
      $display("FAIL wrap_done: got %0d required 7", done_cyc);
    end
  endtask

  task automatic test_backpressure();
    launch(11'h123, 12'd8);
    run_burst(1, 100, 1'b0, "bp_pattern");
    launch(11'h300, 12'd20);
    run_burst(2, 300, 1'b0, "bp_random");
  endtask

  task automatic test_start_while_busy();
    launch(11'h040, 12'd6);
    run_burst(0, 20, 1'b1, "busy_start");
    n_cmp++;
    if (done_cyc != 9) begin
      n_err++;
      $display("FAIL busy_start_done: got %0d required 9", done_cyc);
    end
  endtask

  task automatic test_len0();
    @(negedge rclk);
    start = 1'b1; sadr = 11'h005; len = 12'd0; o_ready = 1'b1;
    @(negedge rclk);
    start = 1'b0;
    #1;
    n_cmp++;
    if ({done, ram_ce, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL len0_c1: got done,ce,busy=%b required 100", {done, ram_ce, busy});
    end
    @(negedge rclk);
    #1;
    n_cmp++;
    if ({done, ram_ce, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL len0_c2: got done,ce,busy=%b required 000", {done, ram_ce, busy});
    end
  endtask

  task automatic test_len_max();
    launch(11'h000, 12'd2048);
    run_burst(0, 2100, 1'b0, "len2048");
    n_cmp++;
    if (done_cyc != 2051) begin
      n_err++;
      $display("FAIL len2048_done: got %0d required 2051", done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    launch(11'h200, 12'd16);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge rclk);
      start = 1'b0; o_ready = 1'b1;
      if (cyc == 5) rrst = 1'b1;
    end
    @(negedge rclk);
    rrst = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, ram_ce, ram_adr, o_valid, o_data, o_last, perr} !== 25'd0) begin
      n_err++;
      $display("FAIL midrst_values: got %h required 0", {busy, done, ram_ce, ram_adr, o_valid, o_data, o_last, perr});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge rclk);
      #1;
      n_cmp++;
      if ({done, o_valid, ram_ce} !== 3'b000) begin
        n_err++;
        $display("FAIL midrst_quiet: got done,valid,ce=%b required 000", {done, o_valid, ram_ce});
      end
    end
    exp_q.delete();
    adr_exp.delete();
    launch(11'h210, 12'd5);
    run_burst(0, 20, 1'b0, "after_rst");
    n_cmp++;
    if (done_cyc != 8) begin
      n_err++;
      $display("FAIL after_rst_done: got %0d required 8", done_cyc);
    end
  endtask

  task automatic test_parity();
    logic exp_perr;
`ifdef SYNCRAM_RDR_PARITY_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    mem[11'h100] = 8'hA5; flip[11'h100] = 1'b1; mem[11'h101] = 8'h3C;
    launch(11'h100, 12'd2);
    run_burst(0, 20, 1'b0, "parity");
    n_cmp++;
    if (perr !== exp_perr) begin
      n_err++;
      $display("FAIL parity_set: got %b required %b", perr, exp_perr);
    end
    launch(11'h105, 12'd3);
    run_burst(0, 20, 1'b0, "parity_clr");
    n_cmp++;
    if (perr_c1 !== 1'b0 || perr !== 1'b0) begin
      n_err++;
      $display("FAIL parity_clear: got %b/%b required 0/0", perr_c1, perr);
    end
    flip[11'h100] = 1'b0;
  endtask

  initial begin
    rrst = 1'b1; start = 1'b0; o_ready = 1'b0; sadr = '0; len = '0;
    for (int i = 0; i < 2048; i++) begin
      mem[i]  = 8'($urandom);
      flip[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_start_while_busy();
    test_len0();
    test_len_max();
    test_reset_mid();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
